// File: rtl/mips_debug_pkg.sv
// Shared types and default sizing for the processor debug dump path.
package mips_debug_pkg;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_DATA_WIDTH_UART = 8;
  localparam int DEF_NREGS           = 32;
  localparam int DEF_NMEM            = 32;
  localparam int DEF_ADDR_WIDTH      = 5;

  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_DATA_WIDTH_UART;
  localparam int DUMP_WORDS     = 1 + DEF_NREGS + DEF_NMEM;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    NEXT,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    PH_PC,
    PH_REGS,
    PH_MEM
  } phase_e;

  function automatic int bytes_per_word(input int dw, input int uw);
    return dw / uw;
  endfunction

  function automatic int idx_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Holds one dump word and walks its bytes LSB first across the UART
// tx_signal/tx_done handshake; the parent FSM supplies LOAD/SEND/WAIT strobes.
module debug_word_serializer
  import mips_debug_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int DATA_WIDTH_UART = DEF_DATA_WIDTH_UART
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_load,
  input  logic [DATA_WIDTH-1:0]      i_word,
  input  logic                       i_single,
  input  logic                       i_send,
  input  logic                       i_wait,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  output logic                       o_byte_done,
  output logic                       o_word_done
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH, DATA_WIDTH_UART);
  localparam int IDX_W = idx_width(BPW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  last_byte;
  logic                  handshake;

  // A single-byte word (the checksum) ends after byte 0.
  assign last_byte   = i_single ? (idx_q == '0) : (idx_q == IDX_LAST);
  assign handshake   = i_wait & i_tx_done;
  assign o_byte_done = handshake & ~last_byte;
  assign o_word_done = handshake & last_byte;
  assign o_tx_signal = i_send;
  assign o_tx_byte   = word_q[DATA_WIDTH_UART*idx_q +: DATA_WIDTH_UART];

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (i_load) begin
      word_d = i_word;
      idx_d  = '0;
    end else if (o_byte_done) begin
      idx_d = idx_q + 1'b1;
    end else if (o_word_done) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/debug_dump_tx.sv
// Serializes PC, registers 0..NREGS-1 and memory 0..NMEM-1 into UART bytes.
// Define DEBUG_DUMP_CHECKSUM_EN to append one XOR checksum byte to each dump.
//
// state  | meaning
// IDLE   | waiting for i_start; register address 0 already on o_reg_addr
// LOAD   | capture PC / register / memory word into the serializer
// SEND   | o_tx_signal pulse for the current byte
// WAIT   | hold byte until i_tx_done
// NEXT   | advance phase; next read address is on the bus this cycle
// FINISH | o_done pulse, back to IDLE
module debug_dump_tx
  import mips_debug_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int DATA_WIDTH_UART = DEF_DATA_WIDTH_UART,
  parameter int NREGS           = DEF_NREGS,
  parameter int NMEM            = DEF_NMEM,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [ADDR_WIDTH-1:0]      o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam logic [ADDR_WIDTH-1:0] REG_LAST = ADDR_WIDTH'(NREGS - 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_LAST = ADDR_WIDTH'(NMEM - 1);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] reg_cnt_q, reg_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] data_word, load_word, csum_word;
  logic                  csum_phase;
  logic                  byte_done, word_done;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH_UART-1:0] csum_q, csum_d;
  logic                       csum_phase_q, csum_phase_d;
  logic                       csum_set;
`endif

  // Counters hold the address of the next word to load, so the read is
  // already on the bus during NEXT (and during IDLE for register 0).
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    reg_cnt_d = reg_cnt_q;
    mem_cnt_d = mem_cnt_q;
    pc_d      = pc_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    csum_set  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          pc_d    = i_pc;
          phase_d = PH_PC;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = SEND;
        if (!csum_phase) begin
          if (phase_q == PH_REGS) begin
            reg_cnt_d = (reg_cnt_q == REG_LAST) ? '0 : reg_cnt_q + 1'b1;
          end else if (phase_q == PH_MEM) begin
            mem_cnt_d = (mem_cnt_q == MEM_LAST) ? '0 : mem_cnt_q + 1'b1;
          end
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (byte_done) begin
          state_d = SEND;
        end else if (word_done) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (csum_phase) begin
          state_d = FINISH;
        end else if (phase_q == PH_PC) begin
          phase_d = PH_REGS;
          state_d = LOAD;
        end else if (phase_q == PH_REGS) begin
          state_d = LOAD;
          if (reg_cnt_q == '0) begin
            phase_d = PH_MEM;
          end
        end else if (mem_cnt_q == '0) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
          csum_set = 1'b1;
          state_d  = LOAD;
`else
          state_d  = FINISH;
`endif
        end else begin
          state_d = LOAD;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      phase_q   <= PH_PC;
      reg_cnt_q <= '0;
      mem_cnt_q <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      reg_cnt_q <= reg_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      pc_q      <= pc_d;
    end
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  // Accumulates every dump byte; the checksum byte itself is excluded.
  always_comb begin
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
    if (state_q == IDLE && i_start) begin
      csum_d       = '0;
      csum_phase_d = 1'b0;
    end else begin
      if (o_tx_signal && !csum_phase_q) begin
        csum_d = csum_q ^ o_tx_byte;
      end
      if (csum_set) begin
        csum_phase_d = 1'b1;
      end else if (state_q == FINISH) begin
        csum_phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
    end else begin
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
    end
  end

  assign csum_phase = csum_phase_q;
  assign csum_word  = DATA_WIDTH'(csum_q);
`else
  assign csum_phase = 1'b0;
  assign csum_word  = '0;
`endif

  always_comb begin
    data_word = i_mem_data;
    if (phase_q == PH_PC) begin
      data_word = pc_q;
    end else if (phase_q == PH_REGS) begin
      data_word = i_reg_data;
    end
    load_word = csum_phase ? csum_word : data_word;
  end

  debug_word_serializer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_WIDTH_UART (DATA_WIDTH_UART)
  ) u_serializer (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (state_q == LOAD),
    .i_word      (load_word),
    .i_single    (csum_phase),
    .i_send      (state_q == SEND),
    .i_wait      (state_q == WAIT),
    .i_tx_done   (i_tx_done),
    .o_tx_signal (o_tx_signal),
    .o_tx_byte   (o_tx_byte),
    .o_byte_done (byte_done),
    .o_word_done (word_done)
  );

  assign o_reg_addr = reg_cnt_q;
  assign o_mem_addr = mem_cnt_q;
  assign o_busy     = (state_q != IDLE) && (state_q != FINISH);
  assign o_done     = (state_q == FINISH);

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed bench for debug_dump_tx: byte-order table, full-stream model compare,
// spurious handshakes, reset mid-dump, back-to-back restart and optional checksum.
module tb_debug_dump_tx;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int N_BYTES = 261;
`else
  localparam int N_BYTES = 260;
`endif
  localparam int BUDGET = 6000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_pc = '0;
  logic [4:0]  reg_addr, mem_addr;
  logic [31:0] reg_rd, mem_rd;
  logic        tx_signal;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        busy, done;

  logic [31:0] regs [32];
  logic [31:0] dmem [32];
  logic [31:0] exp_pc;
  logic [7:0]  rx [$];
  int          rx_base = 0;
  int          done_cnt = 0;
  int          cd, since;
  bit          prev_tx;
  bit          spur_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    int         pos;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  debug_dump_tx dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (i_start),
    .i_pc        (i_pc),
    .o_reg_addr  (reg_addr),
    .i_reg_data  (reg_rd),
    .o_mem_addr  (mem_addr),
    .i_mem_data  (mem_rd),
    .o_tx_signal (tx_signal),
    .o_tx_byte   (tx_byte),
    .i_tx_done   (tx_done),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Synchronous-read register file and data memory: data one cycle after address.
  always @(posedge clk) begin
    reg_rd <= regs[reg_addr];
    mem_rd <= dmem[mem_addr];
  end

  // UART model: done 10 cycles after each tx_signal; optional spurious pulses
  // in SEND and in LOAD (second negedge after a word's final done).
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      cd      = 0;
      since   = 99;
      prev_tx = 1'b0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          tx_done = 1'b1;
          since   = 0;
        end
      end else if (since < 99) begin
        since = since + 1;
      end
      if (spur_en && since == 2 && !prev_tx) tx_done = 1'b1;
      if (tx_signal) begin
        rx.push_back(tx_byte);
        cd = 10;
        if (spur_en) tx_done = 1'b1;
      end
      prev_tx = tx_signal;
      if (done) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    logic [7:0]  x;
    if (k >= 260) begin
      x = '0;
      for (int j = 0; j < 260; j++) x = x ^ exp_byte(j);
      return x;
    end
    if (k / 4 == 0)       w = exp_pc;
    else if (k / 4 < 33)  w = regs[k/4 - 1];
    else                  w = dmem[k/4 - 33];
    return w[8*(k%4) +: 8];
  endfunction

  task automatic fill(input int kind);
    for (int k = 0; k < 32; k++) begin
      case (kind)
        0: begin regs[k] = k * 32'h01010101; dmem[k] = 32'hA0000000 + k; end
        1: begin regs[k] = $urandom; dmem[k] = $urandom; end
        default: begin regs[k] = '0; dmem[k] = '0; end
      endcase
    end
  endtask

  // Called at a negedge; i_pc is scrambled once the start has been taken.
  task automatic pulse_start(output int lat, output logic busy1);
    i_pc    = exp_pc;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_pc    = 32'hDEADBEEF;
    busy1   = busy;
    lat     = 1;
    while (!tx_signal && lat < 20) begin
      @(negedge clk);
      lat = lat + 1;
    end
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!done && c < BUDGET) begin
      @(negedge clk);
      c = c + 1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    int c;
    c = 0;
    while (rx.size() - rx_base < n && c < BUDGET) begin
      @(negedge clk);
      c = c + 1;
    end
    check("reach_byte", 32'(rx.size() - rx_base >= n), 32'd1);
  endtask

  task automatic compare_dump(input string name);
    int bad;
    bad = 0;
    check({name, "_byte_count"}, 32'(rx.size() - rx_base), 32'(N_BYTES));
    for (int k = 0; k < N_BYTES; k++) begin
      if (rx_base + k >= rx.size()) bad = bad + 1;
      else if (rx[rx_base + k] !== exp_byte(k)) bad = bad + 1;
    end
    check({name, "_bad_bytes"}, 32'(bad), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_tx_signal"}, 32'(tx_signal), 32'd0);
    check({name, "_tx_byte"},   32'(tx_byte),   32'd0);
    check({name, "_busy"},      32'(busy),      32'd0);
    check({name, "_done"},      32'(done),      32'd0);
    check({name, "_reg_addr"},  32'(reg_addr),  32'd0);
    check({name, "_mem_addr"},  32'(mem_addr),  32'd0);
  endtask

  initial begin
    int         lat, d0, n0;
    logic       busy1;
    logic [7:0] got;

    vecs[0]  = '{0,   8'h0C};
    vecs[1]  = '{1,   8'h00};
    vecs[2]  = '{3,   8'h00};
    vecs[3]  = '{4,   8'h00};
    vecs[4]  = '{8,   8'h01};
    vecs[5]  = '{11,  8'h01};
    vecs[6]  = '{68,  8'h10};
    vecs[7]  = '{131, 8'h1F};
    vecs[8]  = '{132, 8'h00};
    vecs[9]  = '{135, 8'hA0};
    vecs[10] = '{152, 8'h05};
    vecs[11] = '{256, 8'h1F};
    vecs[12] = '{259, 8'hA0};

    fill(2);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic order
    fill(0);
    exp_pc  = 32'h0000000C;
    rx_base = rx.size();
    pulse_start(lat, busy1);
    d0 = done_cnt;
    check("busy_after_start", 32'(busy1), 32'd1);
    check("start_latency", 32'(lat), 32'd2);
    wait_done("basic_done");
    @(negedge clk);
    check("basic_done_count", 32'(done_cnt - d0), 32'd1);
    check("basic_busy_after", 32'(busy), 32'd0);
    for (int v = 0; v < 13; v++) begin
      got = (rx_base + vecs[v].pos < rx.size()) ? rx[rx_base + vecs[v].pos] : 8'hxx;
      check($sformatf("basic_byte_%0d", vecs[v].pos), 32'(got), 32'(vecs[v].exp));
    end
    compare_dump("basic");

    // Random data with spurious tx_done in SEND/LOAD and restarts while busy
    fill(1);
    exp_pc  = $urandom;
    rx_base = rx.size();
    spur_en = 1'b1;
    pulse_start(lat, busy1);
    d0 = done_cnt;
    wait_bytes(50);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_bytes(150);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("spur_done");
    spur_en = 1'b0;
    @(negedge clk);
    check("spur_done_count", 32'(done_cnt - d0), 32'd1);
    compare_dump("spur");

    // Reset mid-dump
    fill(1);
    exp_pc  = $urandom;
    rx_base = rx.size();
    pulse_start(lat, busy1);
    d0 = done_cnt;
    wait_bytes(37);
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    n0 = rx.size();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_tx", 32'(rx.size()), 32'(n0));
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_stays_idle", 32'(busy), 32'd0);

    fill(1);
    exp_pc  = $urandom;
    rx_base = rx.size();
    pulse_start(lat, busy1);
    d0 = done_cnt;
    check("post_reset_latency", 32'(lat), 32'd2);
    wait_done("post_reset_done");
    got = (rx.size() > rx_base) ? rx[rx_base] : 8'hxx;
    check("post_reset_pc_byte0", 32'(got), 32'(exp_pc[7:0]));
    compare_dump("post_reset");

    // Back-to-back: start during FINISH is dropped, next cycle is taken
    rx_base = rx.size();
    fill(0);
    exp_pc  = 32'h12345678;
    i_pc    = exp_pc;
    i_start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 32'(busy), 32'd0);
    check("post_reset_done_count", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    i_start = 1'b0;
    i_pc    = 32'hDEADBEEF;
    check("b2b_accepted", 32'(busy), 32'd1);
    d0 = done_cnt;
    wait_done("b2b_done");
    @(negedge clk);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd1);
    compare_dump("b2b");

`ifdef DEBUG_DUMP_CHECKSUM_EN
    fill(2);
    exp_pc  = 32'h00000004;
    rx_base = rx.size();
    pulse_start(lat, busy1);
    wait_done("csum_done");
    got = (rx.size() > rx_base + 260) ? rx[rx_base + 260] : 8'hxx;
    check("csum_byte", 32'(got), 32'h04);
    compare_dump("csum");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_dump_tx.md
Name: debug_dump_tx

Overview:
- Debug-unit stage that serializes a processor snapshot into bytes for the UART transmitter.
- Triggered after each step, or after program halt in continuous mode.
- Byte stream order: PC, then registers 0..31, then data memory words 0..31.
- Each word is sent as 4 bytes, least-significant byte first. A full dump is 65 words, 260 bytes.
- Sits between the register file and data memory debug read ports on one side and the UART TX request/done handshake on the other.

Parameters:
- DATA_WIDTH, 32, word width of PC, registers and memory.
- DATA_WIDTH_UART, 8, UART byte width; DATA_WIDTH must be a multiple of it.
- NREGS, 32, number of registers dumped.
- NMEM, 32, number of memory words dumped.
- ADDR_WIDTH, 5, width of the debug read addresses (clog2 of max(NREGS,NMEM)).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a dump.
- i_pc  in  DATA_WIDTH  current PC; sampled on accepted i_start.
- o_reg_addr  out  ADDR_WIDTH  register file debug read address.
- i_reg_data  in  DATA_WIDTH  register data; valid 1 cycle after address.
- o_mem_addr  out  ADDR_WIDTH  data memory debug read address.
- i_mem_data  in  DATA_WIDTH  memory data; valid 1 cycle after address.
- o_tx_signal  out  1  one-cycle pulse: UART should send o_tx_byte.
- o_tx_byte  out  DATA_WIDTH_UART  byte to transmit.
- i_tx_done  in  1  UART one-cycle pulse: byte frame finished.
- o_busy  out  1  high from accepted start until the dump completes.
- o_done  out  1  one-cycle pulse after the last byte's i_tx_done.

Behaviour:
- Reset values (async, immediate): all outputs 0, state IDLE, all counters 0.
- States:
  - IDLE -> LOAD on i_start; o_busy rises the next cycle.
  - LOAD: word_reg <= i_pc for the PC word; for other words, word_reg <= i_reg_data / i_mem_data, selected by phase. Byte index is set to 0.
  - SEND: o_tx_signal = 1 for exactly one cycle; o_tx_byte = word_reg[8*idx +: 8].
  - WAIT: o_tx_byte is held stable. On i_tx_done:
    - if idx < 3: idx++, go to SEND;
    - else go to NEXT.
  - NEXT:
    - Advance the word counter and phase: PC -> REGS -> MEM.
    - Drive the next read address; the data is captured in LOAD one cycle later, so NEXT->LOAD covers the read latency.
    - After MEM word NMEM-1, go to FINISH.
  - FINISH: o_done pulse for 1 cycle, o_busy = 0, go to IDLE.
- Address timing: o_reg_addr / o_mem_addr are driven one cycle before LOAD. The first register address (0) is driven in IDLE when i_start is accepted.
- Counters:
  - Register and memory counters wrap at NREGS-1 / NMEM-1 back to 0 at completion.
  - Byte index is 2 bits and wraps 3 -> 0.
- Request rules:
  - i_start while o_busy is ignored.
  - i_start in the same cycle as o_done is ignored; restart is allowed from the following cycle.
- i_tx_done is sampled only in WAIT; pulses in any other state are dropped.
- i_pc changes after the start is accepted do not affect the dump.
- Reset mid-dump aborts immediately to IDLE. No o_done is issued and no further o_tx_signal pulses occur.
- Minimum latency from i_start to the first o_tx_signal: 2 cycles.

Optional Feature:
- Macro: DEBUG_DUMP_CHECKSUM_EN.
- Defined:
  - After the last memory byte's i_tx_done, the block sends one extra byte: the XOR of all 260 sent bytes.
  - The checksum accumulator clears on an accepted start.
  - o_done follows that byte's i_tx_done; total 261 bytes.
- Undefined: no checksum byte and no accumulator logic; 260 bytes.

Decomposition:
- Shared package mips_debug_pkg holds:
  - state enum (IDLE, LOAD, SEND, WAIT, NEXT, FINISH);
  - phase enum (PH_PC, PH_REGS, PH_MEM);
  - BYTES_PER_WORD = DATA_WIDTH/DATA_WIDTH_UART;
  - DUMP_WORDS = 1+NREGS+NMEM.
- One sub-module is natural: debug_word_serializer.
  - It performs the word -> BYTES_PER_WORD byte send with the tx_signal/tx_done handshake.
  - It reports word_done; the parent sequences phases and addresses.

Test Plan:
- Basic order:
  - Stimulus: pc = 0x0000000C, reg[k] = k*0x01010101, mem[k] = 0xA0000000+k; pulse i_start; UART model returns i_tx_done 10 cycles after each o_tx_signal.
  - Response: bytes 0C 00 00 00, then 00 00 00 00, 01 01 01 01, ..., ending with 1F 00 00 A0; exactly 260 o_tx_signal pulses, one o_done, o_busy low afterwards.
- Read latency:
  - Stimulus: memory returns data only 1 cycle after o_mem_addr.
  - Response: every word matches its address; no word offset by one.
- Spurious handshakes:
  - Stimulus: i_start pulsed during a dump; i_tx_done pulsed while in SEND/LOAD.
  - Response: byte count still 260; no restart; no skipped byte.
- Reset mid-dump:
  - Stimulus: assert i_reset after byte 37.
  - Response: all outputs 0 immediately; no o_done; a new i_start produces a full dump beginning with the PC bytes.
- Back-to-back:
  - Stimulus: i_start in the cycle after o_done.
  - Response: second dump accepted and complete.
- DEBUG_DUMP_CHECKSUM_EN:
  - Stimulus: all regs and mem 0, pc = 0x00000004.
  - Response: byte 261 = 0x04; o_done after it.
